// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard and stall controller for the 5-stage MIPS pipeline.
// Generates forwarding selects, load-use and branch stalls, and a valid/ready
// handshake with a multi-cycle data memory guarded by a timeout watchdog.
// Optional feature macro: HAZARD_PERF_CNT_EN adds the 32-bit stall_cycles
// counter output.
module pipe_hazard_ctrl #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] RsD,
   input  logic [4:0] RtD,
   input  logic [4:0] RsE,
   input  logic [4:0] RtE,
   input  logic [4:0] WriteRegE,
   input  logic [4:0] WriteRegM,
   input  logic [4:0] WriteRegW,
   input  logic       RegWriteE,
   input  logic       RegWriteM,
   input  logic       RegWriteW,
   input  logic       MemtoRegE,
   input  logic       MemtoRegM,
   input  logic       MemWriteM,
   input  logic       BranchD,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       StallF,
   output logic       StallD,
   output logic       StallE,
   output logic       StallM,
   output logic       FlushE,
   output logic       FlushW,
   output logic [1:0] ForwardAE,
   output logic [1:0] ForwardBE,
   output logic       ForwardAD,
   output logic       ForwardBD,
   output logic       mem_err
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0] stall_cycles
`endif
);

   localparam int CW = $clog2(TIMEOUT + 1);
   // The request cycle in IDLE is the first stalled cycle, so WAIT gives up
   // after TIMEOUT-1 further cycles: the total freeze never exceeds TIMEOUT.
   localparam logic [CW-1:0] LAST_CNT = CW'((TIMEOUT >= 2) ? (TIMEOUT - 2) : 0);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_ERR
   } state_t;

   state_t        state, state_nx;
   logic [CW-1:0] wait_cnt, wait_cnt_nx;
   logic          req_raw;
   logic          err_raw;
   logic          memacc;
   logic          memstall;
   logic          lwstall;
   logic          brstall;

   assign memacc = MemtoRegM | MemWriteM;

   // State register and wait counter.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         wait_cnt <= '0;
      end else begin
         state    <= state_nx;
         wait_cnt <= wait_cnt_nx;
      end
   end

   // Handshake next-state logic; request and error flags before reset gating.
   // NOTE: every signal gets a default first so no path can infer a latch.
   always_comb begin
      state_nx    = state;
      wait_cnt_nx = wait_cnt;
      req_raw     = 1'b0;
      err_raw     = 1'b0;
      unique case (state)
         S_IDLE: begin
            req_raw = memacc;
            if (memacc && !mem_ready) begin
               wait_cnt_nx = '0;
               state_nx    = (TIMEOUT <= 1) ? S_ERR : S_WAIT;
            end
         end
         S_WAIT: begin
            req_raw = 1'b1;
            if (mem_ready) begin
               state_nx = S_IDLE;
            end else if (wait_cnt == LAST_CNT) begin
               state_nx = S_ERR;
            end else begin
               wait_cnt_nx = wait_cnt + 1'b1;
            end
         end
         S_ERR: begin
            err_raw = 1'b1;
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   // Forwarding selects; the M stage wins over W because it is younger.
   always_comb begin
      ForwardAE = 2'b00;
      ForwardBE = 2'b00;
      if (RsE != 5'd0 && RegWriteM && WriteRegM == RsE)      ForwardAE = 2'b10;
      else if (RsE != 5'd0 && RegWriteW && WriteRegW == RsE) ForwardAE = 2'b01;
      if (RtE != 5'd0 && RegWriteM && WriteRegM == RtE)      ForwardBE = 2'b10;
      else if (RtE != 5'd0 && RegWriteW && WriteRegW == RtE) ForwardBE = 2'b01;
      ForwardAD = (RsD != 5'd0) && RegWriteM && (WriteRegM == RsD);
      ForwardBD = (RtD != 5'd0) && RegWriteM && (WriteRegM == RtD);
   end

   // Stall/flush priority: reset, then memory freeze, then load-use/branch.
   always_comb begin
      lwstall  = MemtoRegE && (RtE == RsD || RtE == RtD);
      brstall  = BranchD &&
                 ((RegWriteE && (WriteRegE == RsD || WriteRegE == RtD)) ||
                  (MemtoRegM && (WriteRegM == RsD || WriteRegM == RtD)));
      mem_req  = req_raw && !rst;
      mem_err  = err_raw && !rst;
      memstall = mem_req && !mem_ready;
      StallF   = 1'b0;
      StallD   = 1'b0;
      StallE   = 1'b0;
      StallM   = 1'b0;
      FlushE   = 1'b0;
      FlushW   = 1'b0;
      if (rst) begin
         FlushE = 1'b1;
         FlushW = 1'b1;
      end else if (memstall) begin
         StallF = 1'b1;
         StallD = 1'b1;
         StallE = 1'b1;
         StallM = 1'b1;
         FlushW = 1'b1;
      end else if (lwstall || brstall) begin
         StallF = 1'b1;
         StallD = 1'b1;
         FlushE = 1'b1;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   // Saturating count of cycles in which fetch is held.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cycles <= '0;
      end else if (StallF && stall_cycles != 32'hFFFF_FFFF) begin
         stall_cycles <= stall_cycles + 32'd1;
      end
   end
`endif

endmodule
